// File: rtl/epp_reg_bridge_if.sv
// Register-bus side of the EPP bridge: one shared address, a write pulse and a read request.
// The bridge is the master; the register file is the slave and returns read data.
interface epp_reg_bridge_if;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_strobe;
  logic [7:0] reg_rd_data;

  modport master (
    output reg_addr,
    output reg_wr_en,
    output reg_wr_data,
    output reg_rd_strobe,
    input  reg_rd_data
  );

  modport slave (
    input  reg_addr,
    input  reg_wr_en,
    input  reg_wr_data,
    input  reg_rd_strobe,
    output reg_rd_data
  );
endinterface

// File: rtl/epp_reg_bridge.sv
// Digilent EPP slave bridging host address/data cycles onto a simple register bus.
// Latency: wait rises SYNC_STAGES+1 clocks after a write/address strobe falls, SYNC_STAGES+2+RD_LATENCY for data reads.
// Backpressure: host is held by epp_wait; a new strobe is ignored until the previous one is released and the FSM is idle.
module epp_reg_bridge #(
  parameter int NUM_REGS    = 16,
  parameter int AUTO_INC    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             epp_astb,
  input  logic             epp_dstb,
  input  logic             epp_wr,
  output logic             epp_wait,
  inout  wire  [7:0]       epp_db,
  epp_reg_bridge_if.master rb
);

  typedef enum logic [2:0] {
    IDLE,
    A_WR,
    A_RD,
    D_WR,
    D_RD_REQ,
    D_RD_WAIT,
    ACK
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] astb_q, dstb_q, wr_q;
  logic                   astb_s, dstb_s, wr_s;

  logic [7:0] addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] dout_q;
  logic [2:0] cnt_q;
  logic       wait_q;
  logic       cyc_addr_q;
  logic       cyc_read_q;

  logic       in_range;
  logic [7:0] next_addr;
  logic [7:0] rd_val;
  logic       db_oe;

  logic       wr_en;
  logic       rd_stb;
  logic       data_done;
  logic       rd_done;

  // Strobe/direction synchronisers; reset to the idle (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      astb_q <= '1;
      dstb_q <= '1;
      wr_q   <= '1;
    end else begin
      astb_q <= {astb_q[SYNC_STAGES-2:0], epp_astb};
      dstb_q <= {dstb_q[SYNC_STAGES-2:0], epp_dstb};
      wr_q   <= {wr_q[SYNC_STAGES-2:0], epp_wr};
    end
  end

  assign astb_s = astb_q[SYNC_STAGES-1];
  assign dstb_s = dstb_q[SYNC_STAGES-1];
  assign wr_s   = wr_q[SYNC_STAGES-1];

  assign in_range  = ({1'b0, addr_q} < 9'(NUM_REGS));
  assign next_addr = ({1'b0, addr_q} >= 9'(NUM_REGS - 1)) ? 8'h00 : addr_q + 8'd1;
  assign rd_val    = in_range ? rb.reg_rd_data : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    wr_en     = 1'b0;
    rd_stb    = 1'b0;
    data_done = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!astb_s) begin
          state_n = wr_s ? A_RD : A_WR;
        end else if (!dstb_s) begin
          state_n = wr_s ? D_RD_REQ : D_WR;
        end
      end
      A_WR: state_n = ACK;
      A_RD: state_n = ACK;
      D_WR: begin
        wr_en     = in_range;
        data_done = 1'b1;
        state_n   = ACK;
      end
      D_RD_REQ: begin
        rd_stb  = 1'b1;
        state_n = D_RD_WAIT;
      end
      D_RD_WAIT: begin
        if (cnt_q == 3'(RD_LATENCY - 1)) begin
          rd_done   = 1'b1;
          data_done = 1'b1;
          state_n   = ACK;
        end
      end
      ACK: begin
        if (cyc_addr_q ? astb_s : dstb_s) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Host data is captured on entry to the write states, while the strobe is known low,
  // so it is valid for the whole D_WR pulse even if the host releases early.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= 8'h00;
      wr_data_q  <= 8'h00;
      dout_q     <= 8'h00;
      cnt_q      <= 3'd0;
      wait_q     <= 1'b0;
      cyc_addr_q <= 1'b0;
      cyc_read_q <= 1'b0;
    end else begin
      wait_q <= (state_n == A_WR) || (state_n == A_RD) ||
                (state_n == D_WR) || (state_n == ACK);

      if (state == IDLE) begin
        cyc_addr_q <= !astb_s;
        cyc_read_q <= wr_s;
      end

      if (state == IDLE && state_n == D_WR) begin
        wr_data_q <= epp_db;
      end

      if (state == IDLE && state_n == A_RD) begin
        dout_q <= addr_q;
      end else if (rd_done) begin
        dout_q <= rd_val;
      end

      if (state == D_RD_REQ) begin
        cnt_q <= 3'd0;
      end else if (state == D_RD_WAIT) begin
        cnt_q <= cnt_q + 3'd1;
      end

      if (state == IDLE && state_n == A_WR) begin
        addr_q <= epp_db;
      end else if (data_done && AUTO_INC != 0) begin
        addr_q <= next_addr;
      end
    end
  end

  // The bus is only ever driven while the host is waiting on a read acknowledge.
  assign db_oe  = (state == A_RD) || (state == ACK && cyc_read_q);
  assign epp_db = db_oe ? dout_q : 8'hzz;

  assign epp_wait         = wait_q;
  assign rb.reg_addr      = addr_q;
  assign rb.reg_wr_en     = wr_en;
  assign rb.reg_wr_data   = wr_data_q;
  assign rb.reg_rd_strobe = rd_stb;

endmodule

// File: tb/tb_epp_reg_bridge.sv
// Directed bench for epp_reg_bridge: host EPP cycles from a vector table plus hand-written corner cases.
module tb_epp_reg_bridge;
  localparam int SYNC = 2;
  localparam int RDL  = 2;
  localparam int NREG = 16;
  localparam int TMO  = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       epp_astb = 1'b1;
  logic       epp_dstb = 1'b1;
  logic       epp_wr = 1'b1;
  logic       epp_wait;
  logic       host_drive = 1'b0;
  logic [7:0] host_dat = 8'h00;
  logic [7:0] rd_val = 8'h00;
  wire  [7:0] epp_db;

  always #5 clk = ~clk;

  assign epp_db = host_drive ? host_dat : 8'hzz;

  epp_reg_bridge_if rb ();
  assign rb.reg_rd_data = rd_val;

  epp_reg_bridge #(
    .NUM_REGS   (NREG),
    .AUTO_INC   (1),
    .SYNC_STAGES(SYNC),
    .RD_LATENCY (RDL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .epp_astb(epp_astb),
    .epp_dstb(epp_dstb),
    .epp_wr  (epp_wr),
    .epp_wait(epp_wait),
    .epp_db  (epp_db),
    .rb      (rb)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [7:0] wr_addr_seen = 8'h00;
  logic [7:0] wr_data_seen = 8'h00;

  always @(negedge clk) begin
    if (!reset) begin
      if (rb.reg_wr_en) begin
        wr_cnt++;
        wr_addr_seen = rb.reg_addr;
        wr_data_seen = rb.reg_wr_data;
      end
      if (rb.reg_rd_strobe) rd_cnt++;
      if (rb.reg_wr_en || rb.reg_rd_strobe)
        check("strobe_exclusive", int'(rb.reg_wr_en & rb.reg_rd_strobe), 0);
      if (dut.db_oe) begin
        check("drive_needs_wait", int'(epp_wait), 1);
        check("drive_needs_host_read", int'(epp_wr), 1);
        check("drive_vs_host_drive", int'(host_drive), 0);
      end
    end
  end

  // One full host cycle: set direction/data, drop strobe, wait for ack, sample, release, wait for ack drop.
  task automatic epp_cycle(input logic is_addr, input logic is_read, input logic [7:0] wdat,
                           output logic [7:0] rdat, output int lat, output int rel_lat,
                           output logic oe_ack);
    epp_wr     = is_read;
    host_drive = !is_read;
    host_dat   = wdat;
    @(negedge clk);
    if (is_addr) epp_astb = 1'b0;
    else         epp_dstb = 1'b0;
    lat = 0;
    while (lat < TMO) begin
      @(negedge clk);
      lat++;
      if (epp_wait) break;
    end
    rdat   = epp_db;
    oe_ack = dut.db_oe;
    epp_astb = 1'b1;
    epp_dstb = 1'b1;
    rel_lat = 0;
    while (rel_lat < TMO) begin
      @(negedge clk);
      rel_lat++;
      if (!epp_wait) break;
    end
    host_drive = 1'b0;
    epp_wr     = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    string      name;
    logic       is_addr;
    logic       is_read;
    logic [7:0] wdat;
    logic [7:0] rdin;
    logic [7:0] exp_db;
    int         exp_wr;
    logic [7:0] exp_waddr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_addr;
    int         exp_lat;
  } vec_t;

  vec_t vt[$];

  localparam int LW = SYNC + 1;
  localparam int LR = SYNC + 2 + RDL;

  initial begin
    logic [7:0] rdat;
    int         lat, rel_lat, w0, r0;
    logic       oe_ack;

    //        name        addr  rd  wdat   rdin   exp_db wr waddr  wdata  addr   lat
    vt.push_back('{"aw05",    1, 0, 8'h05, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h05, LW});
    vt.push_back('{"dwA7",    0, 0, 8'hA7, 8'h00, 8'h00, 1, 8'h05, 8'hA7, 8'h06, LW});
    vt.push_back('{"aw0F",    1, 0, 8'h0F, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h0F, LW});
    vt.push_back('{"dr3C",    0, 1, 8'h00, 8'h3C, 8'h3C, 0, 8'h00, 8'h00, 8'h00, LR});
    vt.push_back('{"aw20",    1, 0, 8'h20, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h20, LW});
    vt.push_back('{"dw11oor", 0, 0, 8'h11, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, LW});
    vt.push_back('{"aw20b",   1, 0, 8'h20, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h20, LW});
    vt.push_back('{"droor",   0, 1, 8'h00, 8'h55, 8'h00, 0, 8'h00, 8'h00, 8'h00, LR});
    vt.push_back('{"aw42",    1, 0, 8'h42, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h42, LW});
    vt.push_back('{"ar42",    1, 1, 8'h00, 8'h00, 8'h42, 0, 8'h00, 8'h00, 8'h42, LW});
    vt.push_back('{"aw07",    1, 0, 8'h07, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h07, LW});
    vt.push_back('{"dr99",    0, 1, 8'h00, 8'h99, 8'h99, 0, 8'h00, 8'h00, 8'h08, LR});
    vt.push_back('{"dw5A",    0, 0, 8'h5A, 8'h00, 8'h00, 1, 8'h08, 8'h5A, 8'h09, LW});

    repeat (4) @(negedge clk);
    check("rst_wait", int'(epp_wait), 0);
    check("rst_oe", int'(dut.db_oe), 0);
    check("rst_addr", int'(rb.reg_addr), 0);
    check("rst_wr_en", int'(rb.reg_wr_en), 0);
    check("rst_rd_strobe", int'(rb.reg_rd_strobe), 0);
    check("rst_wr_data", int'(rb.reg_wr_data), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    foreach (vt[i]) begin
      rd_val = vt[i].rdin;
      w0 = wr_cnt;
      r0 = rd_cnt;
      epp_cycle(vt[i].is_addr, vt[i].is_read, vt[i].wdat, rdat, lat, rel_lat, oe_ack);
      if (vt[i].is_read) check($sformatf("%s/db", vt[i].name), int'(rdat), int'(vt[i].exp_db));
      check($sformatf("%s/oe_at_ack", vt[i].name), int'(oe_ack), int'(vt[i].is_read));
      check($sformatf("%s/wait_lat", vt[i].name), lat, vt[i].exp_lat);
      check($sformatf("%s/release_lat", vt[i].name), rel_lat, SYNC + 1);
      check($sformatf("%s/wr_pulses", vt[i].name), wr_cnt - w0, vt[i].exp_wr);
      check($sformatf("%s/rd_strobes", vt[i].name), rd_cnt - r0,
            int'(vt[i].is_read && !vt[i].is_addr));
      if (vt[i].exp_wr != 0) begin
        check($sformatf("%s/wr_addr", vt[i].name), int'(wr_addr_seen), int'(vt[i].exp_waddr));
        check($sformatf("%s/wr_data", vt[i].name), int'(wr_data_seen), int'(vt[i].exp_wdata));
      end
      check($sformatf("%s/addr_after", vt[i].name), int'(rb.reg_addr), int'(vt[i].exp_addr));
      check($sformatf("%s/oe_idle", vt[i].name), int'(dut.db_oe), 0);
    end

    // Both strobes fall together on a host write: address cycle wins.
    w0 = wr_cnt;
    r0 = rd_cnt;
    epp_wr = 1'b0; host_drive = 1'b1; host_dat = 8'h09;
    @(negedge clk);
    epp_astb = 1'b0; epp_dstb = 1'b0;
    lat = 0;
    while (lat < TMO) begin @(negedge clk); lat++; if (epp_wait) break; end
    check("both/wait_lat", lat, LW);
    epp_astb = 1'b1; epp_dstb = 1'b1;
    rel_lat = 0;
    while (rel_lat < TMO) begin @(negedge clk); rel_lat++; if (!epp_wait) break; end
    host_drive = 1'b0; epp_wr = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    check("both/addr", int'(rb.reg_addr), 8'h09);
    check("both/wr_pulses", wr_cnt - w0, 0);
    check("both/rd_strobes", rd_cnt - r0, 0);
    check("both/wait_idle", int'(epp_wait), 0);

    // Reset in the ACK of a data read; the held strobe then starts a fresh read at address 0.
    rd_val = 8'hC3;
    epp_wr = 1'b1;
    @(negedge clk);
    epp_dstb = 1'b0;
    lat = 0;
    while (lat < TMO) begin @(negedge clk); lat++; if (epp_wait) break; end
    check("rstack/first_wait", int'(epp_wait), 1);
    check("rstack/first_db", int'(epp_db), 8'hC3);
    reset = 1'b1;
    @(negedge clk);
    check("rstack/wait", int'(epp_wait), 0);
    check("rstack/oe", int'(dut.db_oe), 0);
    check("rstack/addr", int'(rb.reg_addr), 0);
    reset = 1'b0;
    r0 = rd_cnt;
    rd_val = 8'h6E;
    lat = 0;
    while (lat < TMO) begin @(negedge clk); lat++; if (epp_wait) break; end
    check("rstack/new_wait", int'(epp_wait), 1);
    check("rstack/new_db", int'(epp_db), 8'h6E);
    check("rstack/new_rd_strobes", rd_cnt - r0, 1);
    epp_dstb = 1'b1;
    rel_lat = 0;
    while (rel_lat < TMO) begin @(negedge clk); rel_lat++; if (!epp_wait) break; end
    check("rstack/release_lat", rel_lat, SYNC + 1);
    check("rstack/addr_after", int'(rb.reg_addr), 8'h01);
    check("rstack/oe_idle", int'(dut.db_oe), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
